// File: rtl/pci_pkg.sv
// Shared constants and state encoding for the PCI initiator and its helpers.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_READ  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WRITE = 4'b0111;

    localparam int DEVSEL_TIMEOUT = 5;
    localparam int TIMER_W        = 3;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_GNT,
        ADDR,
        DATA,
        ABORT,
        TURN
    } state_t;

    function automatic logic [3:0] bus_cmd(input logic is_write);
        return is_write ? CMD_MEM_WRITE : CMD_MEM_READ;
    endfunction

endpackage

// File: rtl/pci_timeout_counter.sv
// Down-counter that flags the last tolerated cycle without a DEVSEL claim.
module pci_timeout_counter
    import pci_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic enable,
    output logic expired
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= TIMER_W'(DEVSEL_TIMEOUT);
        end else if (enable && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Fires during the cycle whose closing edge is the final unclaimed one.
    assign expired = enable && (cnt == TIMER_W'(1));

endmodule

// File: rtl/pci_initiator.sv
// PCI bus master issuing one memory read or write burst per start request,
// with master-abort on missing DEVSEL and termination on target STOP.
module pci_initiator
    import pci_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    output logic        FRAME,
    output logic        IRDY,
    output wire  [3:0]  CBE,
    inout  wire  [31:0] AD,
    input  logic        TRDY,
    input  logic        DEVSEL,
    input  logic        STOP,
    input  logic        GNT,
    output logic        REQ,
    input  logic        start,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [3:0]  be,
    input  logic [3:0]  count,
    input  logic [31:0] wr_data,
    output logic        wr_pop,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    output logic        busy,
    output logic        done,
    output logic        err_abort,
    output logic        err_stop,
    output logic [3:0]  xfer_cnt
);

    state_t      state, next_state;
    logic        lat_write;
    logic [31:0] lat_addr;
    logic [3:0]  lat_be;
    logic [3:0]  remaining;
    logic        devsel_seen;
    logic        timer_load, timer_enable, timer_expired;
    logic        complete, stop_hit, last_phase;
    logic        ad_oe, cbe_oe;
    logic [31:0] ad_out;
    logic [3:0]  cbe_out;

    pci_timeout_counter u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .load    (timer_load),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    assign complete     = (state == DATA) && !TRDY;
    assign stop_hit     = (state == DATA) && !STOP;
    assign last_phase   = (remaining == 4'd1);
    assign timer_load   = (state == ADDR);
    assign timer_enable = (state == DATA) && DEVSEL && !devsel_seen;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            lat_write   <= 1'b0;
            lat_addr    <= '0;
            lat_be      <= '0;
            remaining   <= '0;
            devsel_seen <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            done        <= 1'b0;
            err_abort   <= 1'b0;
            err_stop    <= 1'b0;
            xfer_cnt    <= '0;
        end else begin
            state    <= next_state;
            rd_valid <= 1'b0;
            done     <= (state == TURN);
            if (state == IDLE && start) begin
                lat_write <= write;
                lat_addr  <= addr;
                lat_be    <= be;
                remaining <= (count == 4'd0) ? 4'd1 : count;
                xfer_cnt  <= '0;
                err_abort <= 1'b0;
                err_stop  <= 1'b0;
            end
            if (state == ADDR) begin
                devsel_seen <= 1'b0;
            end
            if (state == DATA && !DEVSEL) begin
                devsel_seen <= 1'b1;
            end
            if (complete) begin
                xfer_cnt  <= xfer_cnt + 4'd1;
                remaining <= remaining - 4'd1;
                if (!lat_write) begin
                    rd_data  <= AD;
                    rd_valid <= 1'b1;
                end
            end
            if (stop_hit) begin
                err_stop <= 1'b1;
            end
            if (state == DATA && next_state == ABORT && !stop_hit) begin
                err_abort <= 1'b1;
            end
        end
    end

    // STOP takes priority; a STOP-terminated burst reuses the ABORT cycle to
    // drop FRAME one cycle before IRDY.
    always_comb begin
        next_state = state;
        FRAME      = 1'b1;
        IRDY       = 1'b1;
        REQ        = 1'b1;
        busy       = (state != IDLE);
        wr_pop     = 1'b0;
        ad_oe      = 1'b0;
        ad_out     = wr_data;
        cbe_oe     = 1'b0;
        cbe_out    = lat_be;
        case (state)
            IDLE: begin
                if (start) next_state = WAIT_GNT;
            end
            WAIT_GNT: begin
                REQ = 1'b0;
                if (!GNT) next_state = ADDR;
            end
            ADDR: begin
                FRAME      = 1'b0;
                ad_oe      = 1'b1;
                ad_out     = lat_addr;
                cbe_oe     = 1'b1;
                cbe_out    = bus_cmd(lat_write);
                next_state = DATA;
            end
            DATA: begin
                FRAME  = last_phase;
                IRDY   = 1'b0;
                cbe_oe = 1'b1;
                ad_oe  = lat_write;
                wr_pop = complete && lat_write;
                if (stop_hit)                     next_state = ABORT;
                else if (complete && last_phase)  next_state = TURN;
                else if (timer_expired)           next_state = ABORT;
            end
            ABORT: begin
                IRDY       = 1'b0;
                cbe_oe     = 1'b1;
                ad_oe      = lat_write;
                next_state = TURN;
            end
            TURN: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign AD  = ad_oe  ? ad_out  : {32{1'bz}};
    assign CBE = cbe_oe ? cbe_out : {4{1'bz}};

endmodule
